// File: rtl/fs_block_fetch.sv
// Block fetcher: copies one BLKxBLK block of S' samples from SRAM into one half of DPRAM0,
// walking Y, U, V blocks in raster order or fetching an arbitrary block on request.
module fs_block_fetch #(
  parameter int          Y_W    = 320,
  parameter int          UV_W   = 160,
  parameter int          IMG_H  = 240,
  parameter int          BLK    = 8,
  parameter logic [17:0] Y_BASE = 18'd76800,
  parameter logic [17:0] U_BASE = 18'd153600,
  parameter logic [17:0] V_BASE = 18'd192000,
  parameter int          RD_LAT = 3,
  parameter int          DP_AW  = 7
) (
  input  logic             CLOCK_50_I,
  input  logic             Reset,
  input  logic             FS_start,
  input  logic             FS_half,
  input  logic             FS_rand,
  input  logic [1:0]       FS_req_chan,
  input  logic [4:0]       FS_req_row,
  input  logic [5:0]       FS_req_col,
  output logic             FS_busy,
  output logic             FS_done,
  output logic             FS_err,
  output logic             FS_last,
  output logic [1:0]       FS_chan,
  output logic [17:0]      SRAM_address,
  input  logic [15:0]      SRAM_read_data,
  output logic [31:0]      FS_write_data,
  output logic [DP_AW-1:0] FS_write_address,
  output logic             FS_write_enable
);

  localparam int KW = DP_AW - 1;
  localparam int LB = $clog2(BLK);
  localparam logic [6:0] Y_CBN      = 7'(Y_W / BLK);
  localparam logic [6:0] UV_CBN     = 7'(UV_W / BLK);
  localparam logic [5:0] RBN        = 6'(IMG_H / BLK);
  localparam logic [5:0] Y_CB_LAST  = 6'(Y_W / BLK - 1);
  localparam logic [5:0] UV_CB_LAST = 6'(UV_W / BLK - 1);
  localparam logic [4:0] RB_LAST    = 5'(IMG_H / BLK - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic            half_q, half_d;
  logic            err_q, err_d;
  logic [1:0]      chan_q, chan_d;
  logic [4:0]      row_q, row_d;
  logic [5:0]      col_q, col_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   wrIdx_q, wrIdx_d;
  logic [RD_LAT:0] vld_q, vld_d;
  logic [17:0]     addr_q, addr_d;
  logic [1:0]      autoChan_q, autoChan_d;
  logic [4:0]      autoRow_q, autoRow_d;
  logic [5:0]      autoCol_q, autoCol_d;

  logic            vldIn;
  logic [1:0]      selChan;
  logic [4:0]      selRow;
  logic [5:0]      selCol;
  logic            selBad;
  logic [5:0]      autoColLast;

  function automatic logic [17:0] blkAddr(input logic [1:0] ch, input logic [4:0] row,
                                          input logic [5:0] col, input logic [KW-1:0] k);
    logic [17:0] base;
    logic [17:0] pitch;
    logic [17:0] line;
    base  = (ch == 2'd0) ? Y_BASE : (ch == 2'd1) ? U_BASE : V_BASE;
    pitch = (ch == 2'd0) ? 18'(Y_W) : 18'(UV_W);
    line  = 18'(row) * 18'(BLK) + 18'(k >> LB);
    return base + line * pitch + 18'(col) * 18'(BLK) + 18'(k & KW'(BLK - 1));
  endfunction

  always_comb begin
    selChan     = FS_rand ? FS_req_chan : autoChan_q;
    selRow      = FS_rand ? FS_req_row  : autoRow_q;
    selCol      = FS_rand ? FS_req_col  : autoCol_q;
    selBad      = (selChan == 2'd3) || ({1'b0, selRow} >= RBN) ||
                  ({1'b0, selCol} >= ((selChan == 2'd0) ? Y_CBN : UV_CBN));
    autoColLast = (autoChan_q == 2'd0) ? Y_CB_LAST : UV_CB_LAST;
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    half_d     = half_q;
    err_d      = err_q;
    chan_d     = chan_q;
    row_d      = row_q;
    col_d      = col_q;
    k_d        = k_q;
    addr_d     = addr_q;
    autoChan_d = autoChan_q;
    autoRow_d  = autoRow_q;
    autoCol_d  = autoCol_q;
    vldIn      = 1'b0;
    wrIdx_d    = vld_q[RD_LAT] ? wrIdx_q + 1'b1 : wrIdx_q;
    unique case (state_q)
      IDLE: begin
        if (FS_start) begin
          mode_d  = FS_rand;
          half_d  = FS_half;
          chan_d  = selChan;
          row_d   = selRow;
          col_d   = selCol;
          k_d     = '0;
          wrIdx_d = '0;
          // A rejected request skips the fetch entirely and reports through FS_err.
          err_d   = FS_rand && selBad;
          state_d = (FS_rand && selBad) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        addr_d = blkAddr(chan_q, row_q, col_q, k_q);
        vldIn  = 1'b1;
        k_d    = k_q + 1'b1;
        if (&k_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (vld_q[RD_LAT] && (&wrIdx_q)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!mode_q) begin
          if (autoCol_q == autoColLast) begin
            autoCol_d = '0;
            if (autoRow_q == RB_LAST) begin
              autoRow_d  = '0;
              autoChan_d = (autoChan_q == 2'd2) ? 2'd0 : autoChan_q + 2'd1;
            end else begin
              autoRow_d = autoRow_q + 5'd1;
            end
          end else begin
            autoCol_d = autoCol_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Each bit of vld tracks one issued address until its SRAM data arrives.
    vld_d = {vld_q[RD_LAT-1:0], vldIn};
  end

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_q    <= IDLE;
      mode_q     <= 1'b0;
      half_q     <= 1'b0;
      err_q      <= 1'b0;
      chan_q     <= 2'd0;
      row_q      <= '0;
      col_q      <= '0;
      k_q        <= '0;
      wrIdx_q    <= '0;
      vld_q      <= '0;
      addr_q     <= Y_BASE;
      autoChan_q <= 2'd0;
      autoRow_q  <= '0;
      autoCol_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      half_q     <= half_d;
      err_q      <= err_d;
      chan_q     <= chan_d;
      row_q      <= row_d;
      col_q      <= col_d;
      k_q        <= k_d;
      wrIdx_q    <= wrIdx_d;
      vld_q      <= vld_d;
      addr_q     <= addr_d;
      autoChan_q <= autoChan_d;
      autoRow_q  <= autoRow_d;
      autoCol_q  <= autoCol_d;
    end
  end

  assign FS_busy          = (state_q != IDLE);
  assign FS_done          = (state_q == DONE);
  assign FS_err           = FS_done && err_q;
  assign FS_last          = FS_done && !err_q && (chan_q == 2'd2) &&
                            (row_q == RB_LAST) && (col_q == UV_CB_LAST);
  assign FS_chan          = chan_q;
  assign SRAM_address     = addr_q;
  assign FS_write_enable  = vld_q[RD_LAT];
  assign FS_write_address = {half_q, wrIdx_q};
  assign FS_write_data    = {16'd0, SRAM_read_data};

endmodule
